vedic_div8_seq: RTL and testbench



---
 rtl/vedic_div8_seq_if.sv | 37 +++
 rtl/vedic_div8_seq.sv | 191 +++++++++++++++++++
 tb/tb_vedic_div8_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vedic_div8_seq_if.sv
// rtl/vedic_div8_seq_if.sv - start/done handshake and operand/result bundle for the sequential divider
//
// Purpose: groups the divider's request, status and result signals so the
//          requester and the divider connect through a single port.
// Signals:
//   start       - request a division (sampled by the divider only when idle)
//   dividend    - unsigned dividend, WIDTH bits
//   divisor     - unsigned divisor, WIDTH bits
//   busy        - divider is iterating
//   done        - one-cycle pulse, results valid
//   quotient    - registered quotient, WIDTH bits
//   remainder   - registered remainder, WIDTH bits
//   div_by_zero - captured divisor was zero, held with the results
// Modports: master (requester), slave (divider).

interface vedic_div8_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/vedic_div8_seq.sv
// rtl/vedic_div8_seq.sv - iterative restoring divider, one quotient bit per clock
//
// Purpose: unsigned WIDTH/WIDTH division producing quotient and remainder.
//          Each trial subtraction runs through chained 4-bit carry-select
//          adder slices (rem + ~divisor + 1). Divide-by-zero short-circuits
//          to DONE with quotient = all ones and remainder = dividend.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - vedic_div8_seq_if.slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out
// Parameter:
//   WIDTH - operand width, multiple of 4 and at least 4.

module vedic_csa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] sum0;
  logic [4:0] sum1;

  // Both carry-in cases are computed up front; the incoming carry only
  // drives the final select, keeping the slice-to-slice path short.
  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + 5'd1;
  assign sum  = cin ? sum1[3:0] : sum0[3:0];
  assign cout = cin ? sum1[4]   : sum0[4];
endmodule

module vedic_div8_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  vedic_div8_seq_if.slave bus
);
  localparam int NSL = WIDTH / 4;
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] dvd_sr;       // dividend, consumed MSB first
  logic [WIDTH-1:0] dsr;          // captured divisor
  logic [WIDTH-1:0] rem;          // partial remainder
  logic [WIDTH-2:0] quo;          // quotient bits gathered so far
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic             busy_c;
  logic             done_c;
  logic             last_iter;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] rem_nx;
  logic [NSL:0]     carry;
  logic             no_borrow;

  // ---------------------------------------------------------------
  // Trial subtraction datapath
  // ---------------------------------------------------------------
  assign shifted  = {rem, dvd_sr[WIDTH-1]};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    vedic_csa4 u_slice (
      .a    (shifted[4*i +: 4]),
      .b    (~dsr[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (trial[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  // shifted can be WIDTH+1 bits wide; if its top bit is set it already
  // exceeds any WIDTH-bit divisor, so the subtraction cannot borrow.
  assign no_borrow = shifted[WIDTH] | carry[NSL];
  assign rem_nx    = no_borrow ? trial : shifted[WIDTH-1:0];
  assign last_iter = (count == CW'(WIDTH - 1));

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = (bus.divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      S_CALC:  busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sr      <= '0;
      dsr         <= '0;
      rem         <= '0;
      quo         <= '0;
      count       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end else begin
              dvd_sr <= bus.dividend;
              dsr    <= bus.divisor;
              rem    <= '0;
              quo    <= '0;
              count  <= '0;
              dbz_r  <= 1'b0;
            end
          end
        end
        S_CALC: begin
          rem    <= rem_nx;
          quo    <= {quo[WIDTH-3:0], no_borrow};
          dvd_sr <= {dvd_sr[WIDTH-2:0], 1'b0};
          count  <= count + CW'(1);
          // Results are published only on the final edge so the visible
          // outputs never show a half-built quotient.
          if (last_iter) begin
            quotient_r  <= {quo, no_borrow};
            remainder_r <= rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_vedic_div8_seq.sv
// tb/tb_vedic_div8_seq.sv - self-checking bench for vedic_div8_seq
module tb_vedic_div8_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vedic_div8_seq_if #(.WIDTH(W)) bus ();

  vedic_div8_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Issue one division, wait for done (bounded), check results and optionally
  // latency/busy span, then step past the done pulse so the DUT is idle.
  task automatic run_div(input int a, input int b, input string tag, input bit chk_timing);
    int lat;
    int busy_n;
    int q, r, z;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    lat    = 0;
    busy_n = 0;
    while (!bus.done && lat < 40) begin
      busy_n += int'(bus.busy);
      @(negedge clk);
      lat++;
    end
    ref_div(a, b, q, r, z);
    check({tag, ".done_seen"}, bus.done, 1);
    if (chk_timing) begin
      check({tag, ".latency"}, lat, (b == 0) ? 0 : W);
      check({tag, ".busy_cycles"}, busy_n, (b == 0) ? 0 : W);
    end
    check({tag, ".quotient"}, bus.quotient, q);
    check({tag, ".remainder"}, bus.remainder, r);
    check({tag, ".div_by_zero"}, bus.div_by_zero, z);
    if (b != 0) begin
      check({tag, ".identity"}, bus.quotient * b + bus.remainder, a);
      check({tag, ".rem_lt_div"}, 32'(bus.remainder < 8'(b)), 1);
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.done, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, z;
    int pa[4];
    int pb[4];
    int idx, last, cyc, n_busy, n_done;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.quotient", bus.quotient, 0);
    check("rst.remainder", bus.remainder, 0);
    check("rst.div_by_zero", bus.div_by_zero, 0);
    rst = 1'b0;

    run_div(200, 7, "d200_7", 1'b1);
    run_div(255, 1, "d255_1", 1'b1);
    run_div(5, 9, "d5_9", 1'b1);
    run_div(100, 0, "d100_0", 1'b1);
    run_div(9, 3, "d9_3", 1'b1);
    run_div(0, 255, "d0_255", 1'b1);

    // Start pulsed during CALC must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ign.done_seen", bus.done, 1);
    check("ign.quotient", bus.quotient, 28);
    check("ign.remainder", bus.remainder, 4);
    n_busy = 0;
    n_done = 0;
    repeat (14) begin
      @(negedge clk);
      n_busy += int'(bus.busy);
      n_done += int'(bus.done);
    end
    check("ign.no_queue_busy", n_busy, 0);
    check("ign.no_queue_done", n_done, 0);

    // Start held high: one result every W+2 cycles.
    pa = '{143, 60, 255, 17};
    pb = '{11, 7, 16, 3};
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'(pa[0]); bus.divisor = 8'(pb[0]);
    idx = 0; last = 0; cyc = 0;
    while (idx < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        ref_div(pa[idx], pb[idx], q, r, z);
        check($sformatf("held%0d.quotient", idx), bus.quotient, q);
        check($sformatf("held%0d.remainder", idx), bus.remainder, r);
        if (idx > 0) check($sformatf("held%0d.interval", idx), cyc - last, W + 2);
        last = cyc;
        idx++;
        if (idx < 4) begin
          bus.dividend = 8'(pa[idx]);
          bus.divisor  = 8'(pb[idx]);
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("held.count", idx, 4);
    @(negedge clk);

    // Reset on iteration 4 aborts and clears everything.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst.busy", bus.busy, 0);
    check("mid_rst.done", bus.done, 0);
    check("mid_rst.quotient", bus.quotient, 0);
    check("mid_rst.remainder", bus.remainder, 0);
    check("mid_rst.div_by_zero", bus.div_by_zero, 0);
    rst = 1'b0;
    run_div(81, 9, "d81_9", 1'b1);

    // Randomized sweep, mostly nonzero divisors with occasional zero.
    for (int i = 0; i < 250; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = (i % 25 == 0) ? 0 : int'($urandom_range(1, 255));
      run_div(a, b, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
